// File: rtl/memory_bus_wait.sv
// memory_bus_wait: decodes the CPU address into 2**BANK_BITS banks and routes
// reads/writes with a valid/ready handshake, per-bank minimum wait states,
// per-bank ready, an access timeout and bus-error reporting.
module memory_bus_wait #(
  parameter int unsigned                   ADDRESS_WIDTH = 16,
  parameter int unsigned                   DATA_WIDTH    = 8,
  parameter int unsigned                   BANK_BITS     = 2,
  parameter int unsigned                   LOCAL_WIDTH   = 14,
  parameter logic [(2**BANK_BITS)-1:0]     BANK_ENABLE   = 4'b0111,
  parameter logic [(2**BANK_BITS)-1:0]     BANK_WRITABLE = 4'b0101,
  parameter logic [4*(2**BANK_BITS)-1:0]   WAIT_STATES   = 16'h0011,
  parameter int unsigned                   TIMEOUT       = 255
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [ADDRESS_WIDTH-1:0]                address,
  input  logic [DATA_WIDTH-1:0]                   data_in,
  input  logic                                    write_enable,
  input  logic                                    cpu_valid,
  output logic                                    cpu_ready,
  output logic [DATA_WIDTH-1:0]                   data_out,
  output logic                                    bus_error,
  output logic [LOCAL_WIDTH-1:0]                  bank_address,
  output logic [DATA_WIDTH-1:0]                   bank_data_in,
  output logic [(2**BANK_BITS)-1:0]               bank_write_enable,
  output logic [(2**BANK_BITS)-1:0]               bank_read_enable,
  input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0]    bank_data_out,
  input  logic [(2**BANK_BITS)-1:0]               bank_ready
);

  localparam int unsigned NB  = 2**BANK_BITS;
  localparam int unsigned WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [WCW-1:0]          r_wait_count, w_wait_count_nxt;
  logic [BANK_BITS-1:0]    r_bank, w_bank_nxt;
  logic                    r_we, w_we_nxt;
  logic                    r_error, w_error_nxt;
  logic [DATA_WIDTH-1:0]   r_data_out, w_data_out_nxt;
  logic [DATA_WIDTH-1:0]   r_bank_data_in, w_bank_data_in_nxt;
  logic [LOCAL_WIDTH-1:0]  r_bank_address, w_bank_address_nxt;
  logic [NB-1:0]           r_wr_stb, w_wr_stb_nxt;
  logic [NB-1:0]           r_rd_stb, w_rd_stb_nxt;

  logic [BANK_BITS-1:0]    w_sel_bank;
  logic [NB-1:0]           w_sel_onehot;
  logic                    w_reject;
  logic [3:0]              w_cur_ws;
  logic [DATA_WIDTH-1:0]   w_cur_data;
  logic                    w_complete;
  logic                    w_timeout;

  assign w_sel_bank   = address[ADDRESS_WIDTH-1 -: BANK_BITS];
  assign w_sel_onehot = NB'(1) << w_sel_bank;
  assign w_reject     = !BANK_ENABLE[w_sel_bank] ||
                        (write_enable && !BANK_WRITABLE[w_sel_bank]);
  assign w_cur_ws     = WAIT_STATES[4*r_bank +: 4];
  assign w_cur_data   = bank_data_out[r_bank*DATA_WIDTH +: DATA_WIDTH];
  assign w_complete   = (32'(r_wait_count) >= 32'(w_cur_ws)) && bank_ready[r_bank];
  assign w_timeout    = (r_wait_count == WCW'(TIMEOUT - 1));

  assign cpu_ready         = (r_state == S_DONE);
  assign bus_error         = (r_state == S_DONE) && r_error;
  assign data_out          = r_data_out;
  assign bank_address      = r_bank_address;
  assign bank_data_in      = r_bank_data_in;
  assign bank_write_enable = r_wr_stb;
  assign bank_read_enable  = r_rd_stb;

  // Next-state and next-datapath values for the access handshake
  always_comb begin
    w_state_nxt         = r_state;
    w_wait_count_nxt    = r_wait_count;
    w_bank_nxt          = r_bank;
    w_we_nxt            = r_we;
    w_error_nxt         = r_error;
    w_data_out_nxt      = r_data_out;
    w_bank_data_in_nxt  = r_bank_data_in;
    w_bank_address_nxt  = r_bank_address;
    w_wr_stb_nxt        = r_wr_stb;
    w_rd_stb_nxt        = r_rd_stb;
    case (r_state)
      S_IDLE: begin
        if (cpu_valid) begin
          w_bank_nxt         = w_sel_bank;
          w_we_nxt           = write_enable;
          w_bank_address_nxt = address[LOCAL_WIDTH-1:0];
          w_bank_data_in_nxt = data_in;
          if (w_reject) begin
            w_error_nxt = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_error_nxt      = 1'b0;
            w_wait_count_nxt = '0;
            w_wr_stb_nxt     = write_enable ? w_sel_onehot : '0;
            w_rd_stb_nxt     = write_enable ? '0 : w_sel_onehot;
            w_state_nxt      = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // Completion is tested before timeout so it wins on the last cycle
        if (w_complete) begin
          if (!r_we) w_data_out_nxt = w_cur_data;
          w_error_nxt  = 1'b0;
          w_wr_stb_nxt = '0;
          w_rd_stb_nxt = '0;
          w_state_nxt  = S_DONE;
        end else if (w_timeout) begin
          if (!r_we) w_data_out_nxt = '0;
          w_error_nxt  = 1'b1;
          w_wr_stb_nxt = '0;
          w_rd_stb_nxt = '0;
          w_state_nxt  = S_DONE;
        end
        if (!w_timeout) w_wait_count_nxt = r_wait_count + 1'b1;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_wr_stb_nxt = '0;
        w_rd_stb_nxt = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops strobes immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wait_count   <= '0;
      r_bank         <= '0;
      r_we           <= 1'b0;
      r_error        <= 1'b0;
      r_data_out     <= '0;
      r_bank_data_in <= '0;
      r_bank_address <= '0;
      r_wr_stb       <= '0;
      r_rd_stb       <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_wait_count   <= w_wait_count_nxt;
      r_bank         <= w_bank_nxt;
      r_we           <= w_we_nxt;
      r_error        <= w_error_nxt;
      r_data_out     <= w_data_out_nxt;
      r_bank_data_in <= w_bank_data_in_nxt;
      r_bank_address <= w_bank_address_nxt;
      r_wr_stb       <= w_wr_stb_nxt;
      r_rd_stb       <= w_rd_stb_nxt;
    end
  end

endmodule

// File: tb/tb_memory_bus_wait.sv
// Directed testbench for memory_bus_wait with TIMEOUT shortened to 8.
module tb_memory_bus_wait;

  logic        clk;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        write_enable;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [7:0]  data_out;
  logic        bus_error;
  logic [13:0] bank_address;
  logic [7:0]  bank_data_in;
  logic [3:0]  bank_write_enable;
  logic [3:0]  bank_read_enable;
  logic [31:0] bank_data_out;
  logic [3:0]  bank_ready;

  int n_vec = 0;
  int n_err = 0;

  memory_bus_wait #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (8),
    .BANK_BITS     (2),
    .LOCAL_WIDTH   (14),
    .BANK_ENABLE   (4'b0111),
    .BANK_WRITABLE (4'b0101),
    .WAIT_STATES   (16'h0011),
    .TIMEOUT       (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .address           (address),
    .data_in           (data_in),
    .write_enable      (write_enable),
    .cpu_valid         (cpu_valid),
    .cpu_ready         (cpu_ready),
    .data_out          (data_out),
    .bus_error         (bus_error),
    .bank_address      (bank_address),
    .bank_data_in      (bank_data_in),
    .bank_write_enable (bank_write_enable),
    .bank_read_enable  (bank_read_enable),
    .bank_data_out     (bank_data_out),
    .bank_ready        (bank_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU transaction: valid held until cpu_ready (then dropped unless keep),
  // CPU inputs scrambled once a strobe is seen, bank_ready forced high at rdy_at.
  task automatic transact(input string tag, input logic [15:0] a, input logic [7:0] d,
                          input logic we, input logic keep, input int rdy_at,
                          input int exp_lat, input int exp_scnt,
                          input logic [3:0] exp_rd, input logic [3:0] exp_wr,
                          input logic exp_err, input logic [7:0] exp_dout);
    int lat, scnt;
    logic [3:0] rd_or, wr_or;
    logic [13:0] ba;
    logic [7:0] bd;
    logic err, oh_ok, done;
    lat = 0; scnt = 0; rd_or = '0; wr_or = '0; ba = '0; bd = '0;
    err = 1'b0; oh_ok = 1'b1; done = 1'b0;
    address = a; data_in = d; write_enable = we; cpu_valid = 1'b1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!$onehot0({bank_write_enable, bank_read_enable})) oh_ok = 1'b0;
      if ((bank_write_enable | bank_read_enable) != 4'b0000) begin
        scnt++;
        rd_or |= bank_read_enable;
        wr_or |= bank_write_enable;
        ba = bank_address;
        bd = bank_data_in;
        if (scnt == 1) begin
          address = ~a; data_in = ~d; write_enable = ~we;
        end
      end
      if (cpu_ready) begin
        done = 1'b1;
        err = bus_error;
        cpu_valid = keep;
      end else if (lat == rdy_at) begin
        bank_ready = 4'b1111;
      end
    end
    if (!done) begin
      lat = -1;
      cpu_valid = 1'b0;
    end
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/strobe_cycles"}, scnt, exp_scnt);
    check({tag, "/rd_strobe"}, {28'd0, rd_or}, {28'd0, exp_rd});
    check({tag, "/wr_strobe"}, {28'd0, wr_or}, {28'd0, exp_wr});
    check({tag, "/onehot"}, {31'd0, oh_ok}, 32'd1);
    check({tag, "/bus_error"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "/data_out"}, {24'd0, data_out}, {24'd0, exp_dout});
    if (exp_scnt > 0) begin
      check({tag, "/bank_address"}, {18'd0, ba}, {18'd0, a[13:0]});
      check({tag, "/bank_data_in"}, {24'd0, bd}, {24'd0, d});
    end
    if (!keep) begin
      @(negedge clk);
      check({tag, "/ready_pulse_width"}, {31'd0, cpu_ready}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1; cpu_valid = 1'b0; address = '0; data_in = '0; write_enable = 1'b0;
    bank_ready = 4'b1111;
    bank_data_out = {8'hEE, 8'h77, 8'h1B, 8'hA5};
    repeat (3) @(negedge clk);
    check("reset/cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("reset/bus_error", {31'd0, bus_error}, 32'd0);
    check("reset/data_out", {24'd0, data_out}, 32'd0);
    check("reset/strobes", {24'd0, bank_write_enable, bank_read_enable}, 32'd0);
    check("reset/bank_address", {18'd0, bank_address}, 32'd0);
    check("reset/bank_data_in", {24'd0, bank_data_in}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // tag, addr, data, we, keep, rdy_at, lat, strobe cycles, rd, wr, err, data_out
    transact("rd_b0",      16'h0005, 8'h00, 1'b0, 1'b0, 0, 3, 2, 4'b0001, 4'b0000, 1'b0, 8'hA5);
    transact("wr_b0",      16'h0012, 8'h3C, 1'b1, 1'b0, 0, 3, 2, 4'b0000, 4'b0001, 1'b0, 8'hA5);
    transact("wr_ro_b1",   16'h4003, 8'h55, 1'b1, 1'b0, 0, 1, 0, 4'b0000, 4'b0000, 1'b1, 8'hA5);
    transact("rd_unmap_b3",16'hC010, 8'h00, 1'b0, 1'b0, 0, 1, 0, 4'b0000, 4'b0000, 1'b1, 8'hA5);
    transact("rd_b1",      16'h4007, 8'h00, 1'b0, 1'b0, 0, 3, 2, 4'b0010, 4'b0000, 1'b0, 8'h1B);
    transact("wr_b2",      16'h8021, 8'h99, 1'b1, 1'b0, 0, 2, 1, 4'b0000, 4'b0100, 1'b0, 8'h1B);

    bank_ready = 4'b1011;
    transact("rd_b2_slow", 16'h8002, 8'h00, 1'b0, 1'b0, 6, 7, 6, 4'b0100, 4'b0000, 1'b0, 8'h77);

    bank_ready = 4'b1011;
    transact("timeout",    16'h8003, 8'h00, 1'b0, 1'b0, 0, 9, 8, 4'b0100, 4'b0000, 1'b1, 8'h00);

    bank_data_out = {8'hEE, 8'h5A, 8'h1B, 8'hA5};
    bank_ready = 4'b1011;
    transact("ready_at_7", 16'h8004, 8'h00, 1'b0, 1'b0, 8, 9, 8, 4'b0100, 4'b0000, 1'b0, 8'h5A);
    bank_ready = 4'b1111;

    // Reset in the middle of an access stalled on bank 0
    bank_ready = 4'b1110;
    address = 16'h0003; write_enable = 1'b0; cpu_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid/strobe_before", {28'd0, bank_read_enable}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid/rd_async_drop", {28'd0, bank_read_enable}, 32'd0);
    check("rst_mid/wr_async_drop", {28'd0, bank_write_enable}, 32'd0);
    cpu_valid = 1'b0;
    seen = cpu_ready;
    repeat (3) begin
      @(negedge clk);
      seen = seen | cpu_ready;
    end
    reset = 1'b0;
    bank_ready = 4'b1111;
    repeat (4) begin
      @(negedge clk);
      seen = seen | cpu_ready;
    end
    check("rst_mid/no_ready_pulse", {31'd0, seen}, 32'd0);
    check("rst_mid/data_out_cleared", {24'd0, data_out}, 32'd0);

    // Back-to-back: valid held through the cpu_ready cycle
    transact("b2b_first",  16'h0001, 8'h00, 1'b0, 1'b1, 0, 3, 2, 4'b0001, 4'b0000, 1'b0, 8'hA5);
    transact("b2b_second", 16'h4001, 8'h00, 1'b0, 1'b0, 0, 4, 2, 4'b0010, 4'b0000, 1'b0, 8'h1B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
